rb_fetch_controller: RTL

- Sequences raster-order fetch of an IMG_H x IMG_W image from external memory into the K_SIZE-line BRAM row buffer.
- Rotates row-slot write/read pointers and flags each cycle on which a valid K_SIZE x K_SIZE window is at the buffer output.
- Signals completion once the full (IMG_H-K_SIZE+1) x (IMG_W-K_SIZE+1) output image has been produced.
- Sits in top between the external memory port and the row-buffer BRAMs; drives the read/complete strobes the bench samples.

---
 rtl/rb_fetch_controller.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/rb_fetch_controller.sv
// Raster-order fetch sequencer for a K_SIZE-line BRAM row buffer: walks the image, rotates
// row slots, and flags each cycle on which a full K_SIZE x K_SIZE window sits at the buffer output.
module rb_fetch_controller #(
  parameter int unsigned      IMG_W     = 512,
  parameter int unsigned      IMG_H     = 512,
  parameter int unsigned      K_SIZE    = 3,
  parameter int unsigned      PIXEL     = 8,
  parameter int unsigned      EADDR     = 32,
  parameter logic [EADDR-1:0] BASE_ADDR = '0,
  localparam int unsigned     SW        = (K_SIZE > 1) ? $clog2(K_SIZE) : 1,
  localparam int unsigned     CW        = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int unsigned     RW        = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  output logic [EADDR-1:0] e_mem_addr,
  output logic             e_mem_rd,
  output logic             rb_wr_en,
  output logic [SW-1:0]    rb_wr_slot,
  output logic [CW-1:0]    rb_wr_col,
  output logic [SW-1:0]    rb_rd_base,
  output logic             read,
  output logic [RW-1:0]    out_row,
  output logic [CW-1:0]    out_col,
  output logic             busy,
  output logic             complete
);

  localparam logic [CW-1:0]    ColLast     = CW'(IMG_W - 1);
  localparam logic [RW-1:0]    RowLast     = RW'(IMG_H - 1);
  localparam logic [SW-1:0]    SlotLast    = SW'(K_SIZE - 1);
  localparam logic [CW-1:0]    ColFirstWin = CW'(K_SIZE - 1);
  localparam logic [RW-1:0]    RowFirstWin = RW'(K_SIZE - 1);
  localparam logic [EADDR-1:0] LastAddr    = BASE_ADDR + EADDR'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StFlush, StDone} state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [EADDR-1:0]  addr_q, addr_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic              read_q, read_d;
  logic [RW-1:0]     out_row_q, out_row_d;
  logic [CW-1:0]     out_col_q, out_col_d;
  logic [SW-1:0]     rd_base_q, rd_base_d;
  logic              fetch;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    addr_d    = addr_q;
    slot_d    = slot_q;
    read_d    = 1'b0;
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    rd_base_d = rd_base_q;
    fetch     = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StFetch;
          row_d   = '0;
          col_d   = '0;
          slot_d  = '0;
          addr_d  = BASE_ADDR;
        end
      end
      StFetch: begin
        if (!pause) begin
          fetch = 1'b1;
          // Window for this pixel is readable next cycle; the oldest row lives one slot ahead.
          if (row_q >= RowFirstWin && col_q >= ColFirstWin) begin
            read_d    = 1'b1;
            out_row_d = row_q - RowFirstWin;
            out_col_d = col_q - ColFirstWin;
            rd_base_d = (slot_q == SlotLast) ? '0 : slot_q + SW'(1);
          end
          if (col_q == ColLast) begin
            if (row_q == RowLast) begin
              state_d = StFlush;
            end else begin
              col_d  = '0;
              row_d  = row_q + RW'(1);
              addr_d = addr_q + EADDR'(1);
              slot_d = (slot_q == SlotLast) ? '0 : slot_q + SW'(1);
            end
          end else begin
            col_d  = col_q + CW'(1);
            addr_d = addr_q + EADDR'(1);
          end
        end
      end
      StFlush: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      row_q     <= '0;
      col_q     <= '0;
      addr_q    <= '0;
      slot_q    <= '0;
      read_q    <= 1'b0;
      out_row_q <= '0;
      out_col_q <= '0;
      rd_base_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      addr_q    <= addr_d;
      slot_q    <= slot_d;
      read_q    <= read_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      rd_base_q <= rd_base_d;
    end
  end

  assign e_mem_addr = addr_q;
  assign e_mem_rd   = fetch;
  assign rb_wr_en   = fetch;
  assign rb_wr_slot = slot_q;
  assign rb_wr_col  = col_q;
  assign rb_rd_base = rd_base_q;
  assign read       = read_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign busy       = (state_q == StFetch) || (state_q == StFlush);
  assign complete   = (state_q == StDone);

  // Fetches stay inside the frame; PIXEL only sizes the data path outside this block.
  assert property (@(posedge clk) disable iff (rst)
    e_mem_rd |-> (e_mem_addr <= LastAddr && PIXEL > 0));

endmodule
